// File: rtl/l2_req_arbiter_pkg.sv
// Shared types and constants for the two-master L2 request arbiter.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumed by l2_req_arbiter and its interface.
package l2_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

  localparam int L2_BURST_W   = 5;
  localparam int ARB_M_ICACHE = 0;
  localparam int ARB_M_DCACHE = 1;

  // One-hot owner code for a master index.
  function automatic logic [1:0] arb_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Bus bundle between the two cache masters, the arbiter and L2Cache.
// No latency: wires only.
// Busy-based stall: a master stalls while its m_busy bit is high.
interface l2_req_arbiter_if
  import l2_arb_pkg::*;
#(
  parameter int BURST_W = L2_BURST_W
);
  logic [1:0]           m_rreq;
  logic [1:0]           m_wreq;
  logic [63:0]          m_addr;
  logic [2*BURST_W-1:0] m_burst_size;
  logic [63:0]          m_wdata;
  logic [63:0]          m_rdata;
  logic [1:0]           m_busy;
  logic                 l2_rreq;
  logic                 l2_wreq;
  logic [31:0]          l2_addr;
  logic [BURST_W-1:0]   l2_burst_size;
  logic [31:0]          l2_wdata;
  logic [31:0]          l2_rdata;
  logic                 l2_busy;

  // Arbiter view.
  modport slave (
    input  m_rreq, m_wreq, m_addr, m_burst_size, m_wdata, l2_rdata, l2_busy,
    output m_rdata, m_busy, l2_rreq, l2_wreq, l2_addr, l2_burst_size, l2_wdata
  );

  // Environment view: the caches and L2Cache together.
  modport master (
    output m_rreq, m_wreq, m_addr, m_burst_size, m_wdata, l2_rdata, l2_busy,
    input  m_rdata, m_busy, l2_rreq, l2_wreq, l2_addr, l2_burst_size, l2_wdata
  );
endinterface

// File: rtl/l2_req_arbiter_rr_pick2.sv
// Two-way round-robin selector: picks the requester that was not served last.
// Latency: combinational.
// No backpressure; the caller decides when the pick is used.
module rr_pick2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       any
);

  // On a tie the master that did not own last wins; otherwise the lone requester.
  always_comb begin
    any    = |req;
    winner = (req == 2'b11) ? ~last : req[ARB_M_DCACHE];
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Arbitrates ICache (master 0) and DCache (master 1) onto the single L2 port per transaction.
// Latency: grant 1 cycle after request; owner paths are combinational pass-through.
// Non-owner sees busy=1/rdata=0; owner sees L2 busy. Optional counters: L2_ARB_PERF_EN.
module l2_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int BURST_W    = L2_BURST_W,
  parameter int TURNAROUND = 1
) (
  input  logic             clk,
  input  logic             reset,
  l2_req_arbiter_if.slave  bus,
  output logic [1:0]       grant
`ifdef L2_ARB_PERF_EN
  ,
  output logic [63:0]      perf_grants,
  output logic [63:0]      perf_wait
`endif
);

  localparam int I0 = ARB_M_ICACHE;
  localparam int I1 = ARB_M_DCACHE;

  arb_state_e         state, state_nxt;
  logic               last, last_nxt;
  logic [1:0]         req;
  logic               pick, pick_any;
  logic [31:0]        addr_q, wdata_q;
  logic [BURST_W-1:0] burst_q;

  assign req = bus.m_rreq | bus.m_wreq;

  rr_pick2 u_pick (
    .req    (req),
    .last   (last),
    .winner (pick),
    .any    (pick_any)
  );

  // State and round-robin pointer; pointer starts at 1 so ICache wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Next state: release only when the owner has dropped and L2 is idle.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      ARB_IDLE: if (pick_any) state_nxt = pick ? ARB_OWN1 : ARB_OWN0;
      ARB_OWN0: if (!req[I0] && !bus.l2_busy) begin
        last_nxt  = 1'b0;
        state_nxt = (TURNAROUND != 0) ? ARB_TURN : ARB_IDLE;
      end
      ARB_OWN1: if (!req[I1] && !bus.l2_busy) begin
        last_nxt  = 1'b1;
        state_nxt = (TURNAROUND != 0) ? ARB_TURN : ARB_IDLE;
      end
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // Remember the owner's address/burst/data so L2 sees stable values when nobody owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      burst_q <= '0;
    end else if (state == ARB_OWN0) begin
      addr_q  <= bus.m_addr[32*I0 +: 32];
      wdata_q <= bus.m_wdata[32*I0 +: 32];
      burst_q <= bus.m_burst_size[BURST_W*I0 +: BURST_W];
    end else if (state == ARB_OWN1) begin
      addr_q  <= bus.m_addr[32*I1 +: 32];
      wdata_q <= bus.m_wdata[32*I1 +: 32];
      burst_q <= bus.m_burst_size[BURST_W*I1 +: BURST_W];
    end
  end

  // Output steering: owner is wired straight through, everyone else stalls.
  always_comb begin
    grant             = 2'b00;
    bus.l2_rreq       = 1'b0;
    bus.l2_wreq       = 1'b0;
    bus.l2_addr       = addr_q;
    bus.l2_wdata      = wdata_q;
    bus.l2_burst_size = burst_q;
    bus.m_busy        = 2'b11;
    bus.m_rdata       = '0;
    case (state)
      ARB_OWN0: begin
        grant                     = arb_onehot(1'b0);
        bus.l2_rreq               = bus.m_rreq[I0];
        bus.l2_wreq               = bus.m_wreq[I0];
        bus.l2_addr               = bus.m_addr[32*I0 +: 32];
        bus.l2_wdata              = bus.m_wdata[32*I0 +: 32];
        bus.l2_burst_size         = bus.m_burst_size[BURST_W*I0 +: BURST_W];
        bus.m_busy[I0]            = bus.l2_busy;
        bus.m_rdata[32*I0 +: 32]  = bus.l2_rdata;
      end
      ARB_OWN1: begin
        grant                     = arb_onehot(1'b1);
        bus.l2_rreq               = bus.m_rreq[I1];
        bus.l2_wreq               = bus.m_wreq[I1];
        bus.l2_addr               = bus.m_addr[32*I1 +: 32];
        bus.l2_wdata              = bus.m_wdata[32*I1 +: 32];
        bus.l2_burst_size         = bus.m_burst_size[BURST_W*I1 +: BURST_W];
        bus.m_busy[I1]            = bus.l2_busy;
        bus.m_rdata[32*I1 +: 32]  = bus.l2_rdata;
      end
      default: ;
    endcase
  end

`ifdef L2_ARB_PERF_EN
  logic [31:0] grants0_q, grants1_q, wait0_q, wait1_q;

  // Grant counters bump on entry to ownership; wait counters on every non-owner request cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
      wait0_q   <= '0;
      wait1_q   <= '0;
    end else begin
      if (state != ARB_OWN0 && state_nxt == ARB_OWN0) grants0_q <= grants0_q + 32'd1;
      if (state != ARB_OWN1 && state_nxt == ARB_OWN1) grants1_q <= grants1_q + 32'd1;
      if (req[I0] && state != ARB_OWN0)               wait0_q   <= wait0_q + 32'd1;
      if (req[I1] && state != ARB_OWN1)               wait1_q   <= wait1_q + 32'd1;
    end
  end

  assign perf_grants = {grants1_q, grants0_q};
  assign perf_wait   = {wait1_q, wait0_q};
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed, table-driven bench for l2_req_arbiter (TURNAROUND=1).
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// Perf counter checks are compiled in only with L2_ARB_PERF_EN.
module tb_l2_req_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] grant;
`ifdef L2_ARB_PERF_EN
  logic [63:0] perf_grants, perf_wait;
`endif

  int checks = 0;
  int errors = 0;

  l2_req_arbiter_if #(.BURST_W(5)) bus ();

  l2_req_arbiter #(.BURST_W(5), .TURNAROUND(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .grant (grant)
`ifdef L2_ARB_PERF_EN
    ,
    .perf_grants (perf_grants),
    .perf_wait   (perf_wait)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [63:0] ADDR_A = {32'h0000_1A40, 32'h0000_0100};
  localparam logic [63:0] ADDR_W = {32'h0000_2000, 32'h0000_0100};
  localparam logic [31:0] WD0    = 32'h1111_2222;
  localparam logic [31:0] WD1    = 32'hDEAD_BEEF;

  typedef struct {
    logic [1:0]  rreq;
    logic [1:0]  wreq;
    logic        busy;
    logic [63:0] addr;
    logic [1:0]  e_grant;
    logic [1:0]  e_mbusy;
    logic        e_rreq;
    logic        e_wreq;
    logic [31:0] e_addr;
    logic [4:0]  e_burst;
    logic [31:0] e_wdata;
    logic [1:0]  e_rsel;   // which m_rdata slice carries l2_rdata (00 = none)
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic [1:0] rreq, input logic [1:0] wreq, input logic busy,
                              input logic [63:0] addr, input logic [1:0] g, input logic [1:0] mb,
                              input logic er, input logic ew, input logic [31:0] ea,
                              input logic [4:0] eb, input logic [31:0] ed, input logic [1:0] rs);
    vec_t v;
    v.rreq = rreq; v.wreq = wreq; v.busy = busy; v.addr = addr;
    v.e_grant = g; v.e_mbusy = mb; v.e_rreq = er; v.e_wreq = ew;
    v.e_addr = ea; v.e_burst = eb; v.e_wdata = ed; v.e_rsel = rs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rdata_exp(input logic [1:0] rs, input logic [31:0] rd);
    logic [63:0] r;
    r = 64'd0;
    if (rs[0]) r[31:0]  = rd;
    if (rs[1]) r[63:32] = rd;
    return r;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        exp_w;

    // Row data: OWN0 left from reset test, release, TURN, DCache read, protocol
    // violation, DCache write under ICache contention, ICache grant after turnaround.
    vecs[0]  = mk(2'b11, 2'b00, 1'b1, ADDR_A, 2'b01, 2'b11, 1, 0, 32'h0000_0100, 5'd4, WD0, 2'b01);
    vecs[1]  = mk(2'b10, 2'b00, 1'b0, ADDR_A, 2'b01, 2'b10, 0, 0, 32'h0000_0100, 5'd4, WD0, 2'b01);
    vecs[2]  = mk(2'b10, 2'b00, 1'b0, ADDR_A, 2'b00, 2'b11, 0, 0, 32'h0000_0100, 5'd4, WD0, 2'b00);
    vecs[3]  = mk(2'b10, 2'b00, 1'b0, ADDR_A, 2'b00, 2'b11, 0, 0, 32'h0000_0100, 5'd4, WD0, 2'b00);
    vecs[4]  = mk(2'b10, 2'b00, 1'b1, ADDR_A, 2'b10, 2'b11, 1, 0, 32'h0000_1A40, 5'd8, WD1, 2'b10);
    vecs[5]  = mk(2'b10, 2'b00, 1'b1, ADDR_A, 2'b10, 2'b11, 1, 0, 32'h0000_1A40, 5'd8, WD1, 2'b10);
    vecs[6]  = mk(2'b00, 2'b00, 1'b1, ADDR_A, 2'b10, 2'b11, 0, 0, 32'h0000_1A40, 5'd8, WD1, 2'b10);
    vecs[7]  = mk(2'b00, 2'b00, 1'b0, ADDR_A, 2'b10, 2'b01, 0, 0, 32'h0000_1A40, 5'd8, WD1, 2'b10);
    vecs[8]  = mk(2'b00, 2'b00, 1'b0, ADDR_A, 2'b00, 2'b11, 0, 0, 32'h0000_1A40, 5'd8, WD1, 2'b00);
    vecs[9]  = mk(2'b00, 2'b00, 1'b0, ADDR_A, 2'b00, 2'b11, 0, 0, 32'h0000_1A40, 5'd8, WD1, 2'b00);
    vecs[10] = mk(2'b00, 2'b10, 1'b0, ADDR_W, 2'b00, 2'b11, 0, 0, 32'h0000_1A40, 5'd8, WD1, 2'b00);
    vecs[11] = mk(2'b01, 2'b10, 1'b1, ADDR_W, 2'b10, 2'b11, 0, 1, 32'h0000_2000, 5'd8, WD1, 2'b10);
    vecs[12] = mk(2'b01, 2'b00, 1'b0, ADDR_W, 2'b10, 2'b01, 0, 0, 32'h0000_2000, 5'd8, WD1, 2'b10);
    vecs[13] = mk(2'b01, 2'b00, 1'b0, ADDR_W, 2'b00, 2'b11, 0, 0, 32'h0000_2000, 5'd8, WD1, 2'b00);
    vecs[14] = mk(2'b01, 2'b00, 1'b0, ADDR_A, 2'b00, 2'b11, 0, 0, 32'h0000_2000, 5'd8, WD1, 2'b00);
    vecs[15] = mk(2'b01, 2'b00, 1'b0, ADDR_A, 2'b01, 2'b10, 1, 0, 32'h0000_0100, 5'd4, WD0, 2'b01);
    vecs[16] = mk(2'b00, 2'b00, 1'b0, ADDR_A, 2'b01, 2'b10, 0, 0, 32'h0000_0100, 5'd4, WD0, 2'b01);
    vecs[17] = mk(2'b00, 2'b00, 1'b0, ADDR_A, 2'b00, 2'b11, 0, 0, 32'h0000_0100, 5'd4, WD0, 2'b00);

    bus.m_rreq       = 2'b11;
    bus.m_wreq       = 2'b00;
    bus.m_addr       = ADDR_A;
    bus.m_burst_size = {5'd8, 5'd4};
    bus.m_wdata      = {WD1, WD0};
    bus.l2_busy      = 1'b0;
    bus.l2_rdata     = 32'h5555_5555;

    // Reset held with both masters requesting.
    repeat (5) @(posedge clk);
    #1;
    chk("reset grant",   64'(grant), 64'(2'b00));
    chk("reset m_busy",  64'(bus.m_busy), 64'(2'b11));
    chk("reset l2_rreq", 64'(bus.l2_rreq), 64'(1'b0));
    chk("reset l2_addr", 64'(bus.l2_addr), 64'd0);
    chk("reset m_rdata", bus.m_rdata, 64'd0);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("first grant",   64'(grant), 64'(2'b01));
    chk("first l2_addr", 64'(bus.l2_addr), 64'h0000_0100);

    // Table rows.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rd            = 32'hA000_0000 | 32'(i);
      bus.m_rreq    = vecs[i].rreq;
      bus.m_wreq    = vecs[i].wreq;
      bus.l2_busy   = vecs[i].busy;
      bus.m_addr    = vecs[i].addr;
      bus.l2_rdata  = rd;
      #1;
      chk($sformatf("row%0d grant", i),   64'(grant), 64'(vecs[i].e_grant));
      chk($sformatf("row%0d m_busy", i),  64'(bus.m_busy), 64'(vecs[i].e_mbusy));
      chk($sformatf("row%0d l2_rreq", i), 64'(bus.l2_rreq), 64'(vecs[i].e_rreq));
      chk($sformatf("row%0d l2_wreq", i), 64'(bus.l2_wreq), 64'(vecs[i].e_wreq));
      chk($sformatf("row%0d l2_addr", i), 64'(bus.l2_addr), 64'(vecs[i].e_addr));
      chk($sformatf("row%0d burst", i),   64'(bus.l2_burst_size), 64'(vecs[i].e_burst));
      chk($sformatf("row%0d l2_wdata", i), 64'(bus.l2_wdata), 64'(vecs[i].e_wdata));
      chk($sformatf("row%0d m_rdata", i), bus.m_rdata, rdata_exp(vecs[i].e_rsel, rd));
    end

    // Ten consecutive ties; ICache owned last, so DCache wins the first.
    exp_w = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      bus.m_rreq  = 2'b11;
      bus.l2_busy = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("tie%0d grant", t), 64'(grant), exp_w ? 64'(2'b10) : 64'(2'b01));
      @(negedge clk);
      bus.m_rreq = 2'b00;
      @(posedge clk);
      @(posedge clk);
      exp_w = ~exp_w;
    end

    // DCache read held busy by L2 for 12 cycles, then release through TURN.
    @(negedge clk);
    bus.m_rreq  = 2'b10;
    bus.m_addr  = ADDR_A;
    bus.l2_busy = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("dread%0d grant", c), 64'(grant), 64'(2'b10));
      chk($sformatf("dread%0d burst", c), 64'(bus.l2_burst_size), 64'd8);
    end
    @(negedge clk);
    bus.m_rreq  = 2'b00;
    bus.l2_busy = 1'b0;
    #1;
    chk("dread drop grant", 64'(grant), 64'(2'b10));
    @(negedge clk);
    #1;
    chk("dread turn grant",  64'(grant), 64'(2'b00));
    chk("dread turn m_busy", 64'(bus.m_busy), 64'(2'b11));
    @(negedge clk);
    #1;
    chk("dread idle grant",  64'(grant), 64'(2'b00));

    // Asynchronous reset in the middle of a DCache transaction.
    @(negedge clk);
    bus.m_rreq  = 2'b10;
    bus.l2_busy = 1'b1;
    @(negedge clk);
    #1;
    chk("pre-reset grant", 64'(grant), 64'(2'b10));
    reset = 1'b0;
    #1;
    chk("async reset grant",   64'(grant), 64'(2'b00));
    chk("async reset m_busy",  64'(bus.m_busy), 64'(2'b11));
    chk("async reset l2_addr", 64'(bus.l2_addr), 64'd0);
    @(negedge clk);
    bus.m_rreq  = 2'b00;
    bus.l2_busy = 1'b0;
    reset       = 1'b1;

`ifdef L2_ARB_PERF_EN
    // Three ICache grants; DCache waits seven cycles during the third.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.m_rreq = 2'b01;
      @(posedge clk);
      if (k == 2) begin
        @(negedge clk);
        bus.m_rreq = 2'b11;
        repeat (7) @(posedge clk);
      end
      @(negedge clk);
      bus.m_rreq = 2'b00;
      @(posedge clk);
      @(posedge clk);
    end
    #1;
    chk("perf grants0", 64'(perf_grants[31:0]), 64'd3);
    chk("perf grants1", 64'(perf_grants[63:32]), 64'd0);
    chk("perf wait1",   64'(perf_wait[63:32]), 64'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
